// File: rtl/input_debounce.sv
// Synchronises a raw asynchronous input, then filters out pulses shorter than
// DEBOUNCE_CYCLES clocks, producing a clean level plus one-cycle rise/fall strobes.
module input_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    input  logic enable,
    output logic out,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic [0:0] {
        StStable,
        StCheck
    } state_e;

    localparam logic [CNT_W-1:0] CntTarget   = CNT_W'(DEBOUNCE_CYCLES);
    localparam bit               SingleCycle = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    logic             s;
    logic [CNT_W-1:0] cnt_inc;

    // The chain shifts every cycle regardless of enable so s is always current.
    assign sync_d  = {sync_q[SYNC_STAGES-2:0], in};
    assign s       = sync_q[SYNC_STAGES-1];
    assign cnt_inc = count_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (!enable) begin
            state_d = StStable;
            count_d = '0;
        end else begin
            unique case (state_q)
                StStable: begin
                    if (s != out_q) begin
                        count_d = CNT_W'(1);
                        if (SingleCycle) begin
                            out_d  = ~out_q;
                            rise_d = ~out_q;
                            fall_d = out_q;
                        end else begin
                            state_d = StCheck;
                        end
                    end else begin
                        count_d = '0;
                    end
                end
                StCheck: begin
                    if (s == out_q) begin
                        // Input fell back before qualifying: treat as a glitch.
                        state_d = StStable;
                        count_d = '0;
                    end else if (cnt_inc == CntTarget) begin
                        out_d   = ~out_q;
                        rise_d  = ~out_q;
                        fall_d  = out_q;
                        count_d = '0;
                        state_d = StStable;
                    end else begin
                        count_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = StStable;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= '0;
            state_q <= StStable;
            count_q <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            count_q <= count_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == StCheck);

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce: a 2-stage/4-cycle instance covers the main
// behaviour, a 2-stage/1-cycle instance covers the single-sample corner.
module tb_input_debounce;

    logic clk;
    logic reset;
    logic in1, enable1;
    logic out1, rise1, fall1, busy1;
    logic in2;
    logic out2, rise2, fall2, busy2;

    int checks = 0;
    int errors = 0;

    input_debounce #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (5)
    ) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .in    (in1),
        .enable(enable1),
        .out   (out1),
        .rise  (rise1),
        .fall  (fall1),
        .busy  (busy1)
    );

    input_debounce #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(1),
        .CNT_W          (2)
    ) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .in    (in2),
        .enable(1'b1),
        .out   (out2),
        .rise  (rise2),
        .fall  (fall2),
        .busy  (busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic eo, input logic er, input logic ef,
                           input logic eb);
        check({tag, " out"}, out1, eo);
        check({tag, " rise"}, rise1, er);
        check({tag, " fall"}, fall1, ef);
        check({tag, " busy"}, busy1, eb);
    endtask

    task automatic check_b(input string tag, input logic eo, input logic er, input logic ef,
                           input logic eb);
        check({tag, " out"}, out2, eo);
        check({tag, " rise"}, rise2, er);
        check({tag, " fall"}, fall2, ef);
        check({tag, " busy"}, busy2, eb);
    endtask

    initial begin
        reset   = 1'b0;
        in1     = 1'b1;
        enable1 = 1'b1;
        in2     = 1'b0;

        // 1: reset held 3 cycles with in high, then released
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_a($sformatf("t1 rst e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
            check_b($sformatf("t1 rst n1 e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        reset = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_a($sformatf("t1 e%0d", e), e >= 6, e == 6, 1'b0, e >= 3 && e <= 5);
        end

        // falling qualification back to 0
        in1 = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_a($sformatf("fall e%0d", e), e < 6, 1'b0, e == 6, e >= 3 && e <= 5);
        end

        // 2: clean 0->1 step
        in1 = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_a($sformatf("t2 e%0d", e), e >= 6, e == 6, 1'b0, e >= 3 && e <= 5);
        end
        in1 = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_a($sformatf("t2f e%0d", e), e < 6, 1'b0, e == 6, e >= 3 && e <= 5);
        end

        // 3: 3-cycle pulse is rejected one edge before it would qualify
        for (int e = 1; e <= 9; e++) begin
            in1 = (e <= 3);
            tick();
            check_a($sformatf("t3 e%0d", e), 1'b0, 1'b0, 1'b0, e >= 3 && e <= 5);
        end

        // 4: bouncing every 2 cycles for 12 cycles, final hold starts at edge 13
        for (int e = 1; e <= 20; e++) begin
            in1 = (e >= 13) ? 1'b1 : (((e - 1) / 2) % 2 == 0);
            tick();
            check($sformatf("t4 out e%0d", e), out1, e >= 18);
            check($sformatf("t4 rise e%0d", e), rise1, e == 18);
            check($sformatf("t4 fall e%0d", e), fall1, 1'b0);
        end

        // 5: out=1, in drops, enable low at edges 4 and 5
        for (int e = 1; e <= 10; e++) begin
            in1     = 1'b0;
            enable1 = !(e == 4 || e == 5);
            tick();
            check_a($sformatf("t5 e%0d", e), e < 9, 1'b0, e == 9, e == 3 || (e >= 6 && e <= 8));
        end
        enable1 = 1'b1;

        // reset in the middle of a qualification
        in1 = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            reset = (e != 4);
            tick();
            check_a($sformatf("rmid e%0d", e), 1'b0, 1'b0, 1'b0, e == 3);
        end
        reset = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_a($sformatf("rmid post e%0d", e), e >= 6, e == 6, 1'b0, e >= 3 && e <= 5);
        end

        // 6: single-cycle debounce toggles at edge SYNC_STAGES+1, never busy
        in2 = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check_b($sformatf("t6 e%0d", e), e >= 3, e == 3, 1'b0, 1'b0);
        end
        in2 = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            check_b($sformatf("t6f e%0d", e), e < 3, 1'b0, e == 3, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
